// File: rtl/apt_rule_writer.sv
// APT SRAM slice update engine: sweeps every row address and writes one rule column
// with the ternary match result of that address, or clears the column on delete.
module apt_rule_writer #(
  parameter int w = 16,
  parameter int b = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           upd_valid,
  output logic           upd_ready,
  input  logic [b-1:0]   upd_idx,
  input  logic [w-1:0]   upd_value,
  input  logic [w-1:0]   upd_mask,
  input  logic           upd_delete,
  output logic           ram_we,
  input  logic           ram_gnt,
  output logic [w-1:0]   ram_addr,
  output logic [0:2**b-1] ram_wdata,
  output logic [0:2**b-1] ram_bwe,
  output logic           upd_busy,
  output logic           upd_done,
  output logic [w:0]     upd_match_cnt
);

  localparam int K = 2**b;
  localparam logic [w-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e       state_q, state_d;
  logic [b-1:0] idx_q, idx_d;
  logic [w-1:0] value_q, value_d;
  logic [w-1:0] mask_q, mask_d;
  logic         delete_q, delete_d;
  logic [w-1:0] addr_q, addr_d;
  logic [w:0]   cnt_q, cnt_d;
  logic         match_bit;

  // Masked-off bits are don't-care; a delete forces the column to zero.
  assign match_bit = !delete_q && (((addr_q ^ value_q) & mask_q) == '0);

  assign ram_addr      = addr_q;
  assign upd_match_cnt = cnt_q;

  // NOTE: every variable gets its default before the case so no path infers a latch;
  // combinational logic uses blocking '=', the state register below uses '<='.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    value_d   = value_q;
    mask_d    = mask_q;
    delete_d  = delete_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    upd_ready = 1'b0;
    upd_busy  = 1'b0;
    upd_done  = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_bwe   = '0;

    unique case (state_q)
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          idx_d    = upd_idx;
          value_d  = upd_value;
          mask_d   = upd_mask;
          delete_d = upd_delete;
          addr_d   = '0;
          cnt_d    = '0;
          state_d  = SWEEP;
        end
      end
      SWEEP: begin
        upd_busy         = 1'b1;
        ram_we           = 1'b1;
        ram_wdata        = {K{match_bit}};
        ram_bwe[idx_q]   = 1'b1;
        // Without a grant everything holds, so the same write is simply retried.
        if (ram_gnt) begin
          cnt_d  = cnt_q + (w+1)'(match_bit);
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = DONE;
        end
      end
      DONE: begin
        upd_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      value_q  <= '0;
      mask_q   <= '0;
      delete_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      mask_q   <= mask_d;
      delete_q <= delete_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apt_rule_writer.sv
// Bench for apt_rule_writer (w=4, b=2): per-row expected writes are queued at request
// acceptance and consumed as granted writes appear; columns are re-checked from the rules.
module tb_apt_rule_writer;

  localparam int W = 4;
  localparam int B = 2;
  localparam int K = 4;
  localparam int ROWS = 16;

  typedef struct {
    logic [W-1:0] addr;
    logic [0:K-1] wdata;
    logic [0:K-1] bwe;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         upd_valid;
  logic         upd_ready;
  logic [B-1:0] upd_idx;
  logic [W-1:0] upd_value;
  logic [W-1:0] upd_mask;
  logic         upd_delete;
  logic         ram_we;
  logic         ram_gnt;
  logic [W-1:0] ram_addr;
  logic [0:K-1] ram_wdata;
  logic [0:K-1] ram_bwe;
  logic         upd_busy;
  logic         upd_done;
  logic [W:0]   upd_match_cnt;

  apt_rule_writer #(.w(W), .b(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_value(upd_value), .upd_mask(upd_mask), .upd_delete(upd_delete),
    .ram_we(ram_we), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_bwe(ram_bwe),
    .upd_busy(upd_busy), .upd_done(upd_done), .upd_match_cnt(upd_match_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_done  = 0;
  int stalls  = 0;
  int a5_cnt  = 0;
  int acc_hist [16];
  wr_t wr_q [$];
  int  cnt_exp_q [$];
  int  acc_q [$];
  logic [0:K-1] dut_ram [ROWS];

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic mbit(input int a, input int val, input int msk, input int del);
    return (del == 0) && (((a ^ val) & msk & 15) == 0);
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: consume expected writes as the DUT commits them, queue new ones on accept.
  always @(negedge clk) begin
    wr_t e;
    int  acc;
    if (rst_n) begin
      if (upd_busy || upd_done) check("ready_low", int'(upd_ready), 0);
      if (wr_q.size() > 0 && !ram_gnt) stalls++;
      if (ram_we) begin
        if (wr_q.size() == 0) check("spurious_we", 1, 0);
        else begin
          e = wr_q[0];
          check("addr", int'(ram_addr), int'(e.addr));
          if (ram_addr == 4'd5) a5_cnt++;
          if (ram_gnt) begin
            check("wdata", int'(ram_wdata), int'(e.wdata));
            check("bwe", int'(ram_bwe), int'(e.bwe));
            for (int l = 0; l < K; l++)
              if (ram_bwe[l]) dut_ram[ram_addr][l] = ram_wdata[l];
            void'(wr_q.pop_front());
          end
        end
      end else if (wr_q.size() > 0) begin
        check("we_missing", 0, 1);
      end
      if (upd_done) begin
        n_done++;
        check("busy_at_done", int'(upd_busy), 0);
        check("pending_at_done", wr_q.size(), 0);
        if (acc_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          acc = acc_q.pop_front();
          check("done_cycle", cyc + 1, acc + 17 + stalls);
          check("match_cnt", int'(upd_match_cnt), cnt_exp_q.pop_front());
        end
      end
      if (upd_valid && upd_ready) begin
        acc = cyc + 1;
        acc_q.push_back(acc);
        acc_hist[n_acc] = acc;
        n_acc++;
        stalls = 0;
        for (int a = 0; a < ROWS; a++) begin
          e.addr  = W'(a);
          e.bwe   = 4'b1000 >> upd_idx;
          e.wdata = {K{mbit(a, int'(upd_value), int'(upd_mask), int'(upd_delete))}};
          wr_q.push_back(e);
        end
        cnt_exp_q.push_back(upd_delete ? 0 : (1 << (W - $countones(upd_mask))));
      end
    end
  end

  task automatic req(input int idx, input int val, input int msk, input int del, input bit keep);
    int n0 = n_acc;
    int t  = 0;
    upd_idx    = B'(idx);
    upd_value  = W'(val);
    upd_mask   = W'(msk);
    upd_delete = (del != 0);
    upd_valid  = 1'b1;
    while (n_acc == n0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (n_acc == n0) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) upd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_timeout", n_done, target);
    @(posedge clk); #1;
  endtask

  task automatic wait_addr(input int a);
    int t = 0;
    while (!(ram_we && ram_addr == W'(a)) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("reach_addr", int'(ram_addr), a);
  endtask

  task automatic check_col(input int idx, input int val, input int msk, input int del);
    for (int r = 0; r < ROWS; r++)
      check("ram_col", int'(dut_ram[r][idx]), int'(mbit(r, val, msk, del)));
  endtask

  task automatic check_reset_outputs;
    check("rst_ready", int'(upd_ready), 1);
    check("rst_we", int'(ram_we), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_wdata", int'(ram_wdata), 0);
    check("rst_bwe", int'(ram_bwe), 0);
    check("rst_busy", int'(upd_busy), 0);
    check("rst_done", int'(upd_done), 0);
    check("rst_cnt", int'(upd_match_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < ROWS; r++) dut_ram[r] = 4'b0101;
    rst_n = 1'b0; upd_valid = 1'b0; upd_idx = '0; upd_value = '0;
    upd_mask = '0; upd_delete = 1'b0; ram_gnt = 1'b1;
    #3;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact-match rule: only addr 10 matches.
    req(2, 'hA, 'hF, 0, 0);
    wait_done(1);
    check_col(2, 'hA, 'hF, 0);

    // Full wildcard: every row matches, count reaches 2**w.
    req(0, 'h5, 'h0, 0, 0);
    wait_done(2);
    check_col(0, 'h5, 'h0, 0);

    // Prefix rule on the top two bits, then delete the same column.
    req(3, 'h4, 'hC, 0, 0);
    wait_done(3);
    check_col(3, 'h4, 'hC, 0);
    req(3, 'h0, 'h0, 1, 0);
    wait_done(4);
    for (int r = 0; r < ROWS; r++) check("col3_clear", int'(dut_ram[r][3]), 0);

    // Grant withheld for three cycles at addr 5.
    a5_cnt = 0;
    req(2, 'hA, 'hF, 0, 0);
    wait_addr(5);
    ram_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 ram_gnt = 1'b1;
    wait_done(5);
    check("addr5_hold", a5_cnt, 4);
    check_col(2, 'hA, 'hF, 0);

    // Reset in the middle of a sweep aborts at once.
    req(1, 'h3, 'hF, 0, 0);
    wait_addr(7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    wr_q.delete(); cnt_exp_q.delete(); acc_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_no_we", int'(ram_we), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", n_done, 5);
    req(1, 'h3, 'hF, 0, 0);
    wait_done(6);
    check_col(1, 'h3, 'hF, 0);

    // Back-to-back requests with valid held high.
    req(0, 'h9, 'hF, 0, 1);
    req(1, 'h2, 'h3, 0, 0);
    wait_done(8);
    check("b2b_gap", acc_hist[n_acc-1] - acc_hist[n_acc-2], 18);
    check_col(0, 'h9, 'hF, 0);
    check_col(1, 'h2, 'h3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
